muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle HI/LO multiply/divide unit for the MIPS pipeline, replacing the single-step multiply/divide path behind the decoder's `MULOp`/`mumu`/`hazmulti` outputs. It is parametrised in data width and per-class latency, adds multiply-accumulate modes (madd/maddu/msub/msubu) and an exception flush. It sits beside the EX-stage ALU. `busy` feeds the hazard logic so mflo/mfhi/mtlo/mthi and new mul/div ops stall while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_LAT`, 5: cycles for mult/multu/madd/maddu/msub/msubu; must be at least 1.
- `DIV_LAT`, 10: cycles for div/divu; must be at least 1.

- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  issue strobe, sampled with `mul_op`.
- `mul_op`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu.
- `src_a`, `src_b`  in  WIDTH  rs and rt operands.
- `wr_hi`, `wr_lo`  in  1  mthi and mtlo strobes.
- `wr_data`  in  WIDTH  mthi/mtlo data.
- `flush`  in  1  exception/eret cancel.
- `busy`  out  1  operation in flight.
- `hi`, `lo`  out  WIDTH  architectural HI and LO registers.

## Operation
- **Reset:** `hi`=0, `lo`=0, `busy`=0, counter=0, pending result cleared.
- **States:** IDLE and RUN.
- **IDLE → RUN:** `start`=1, `mul_op` in 1..8, `flush`=0.
  - Operands are latched.
  - The counter is loaded with MUL_LAT or DIV_LAT.
  - The result is computed from the latched operands.
- **Ignored issues:** `start` with `mul_op` equal to 0 or 9..15 is ignored. `start` while in RUN is ignored.
- **RUN:** the counter decrements every cycle. At the edge where it reaches 0, the result commits to `hi`/`lo` and the state returns to IDLE.
- **Product rules:**
  - Products are 2·WIDTH bits. Signed ops sign-extend the operands; unsigned ops zero-extend them.
  - mult/multu: {hi,lo} = product.
- **Divide rules:**
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - `lo` = quotient, `hi` = remainder.
  - Divide by zero: `lo` = all ones, `hi` = dividend. No trap.
  - Signed overflow (min ÷ −1): `lo` = min, `hi` = 0.
- **Multiply-accumulate:**
  - madd/maddu: {hi,lo} += product. msub/msubu: {hi,lo} −= product.
  - Arithmetic is modulo 2^(2·WIDTH).
  - The accumulator is the {hi,lo} value at commit time, not at issue.
- **mthi/mtlo (`wr_hi`/`wr_lo`):**
  - Accepted in IDLE; the register takes `wr_data` at the edge.
  - Ignored in RUN.
  - When a write coincides with an accepted `start`, both take effect. An accumulate op then accumulates onto the written value.
- **Flush:**
  - `flush` in RUN: the operation is discarded, the state goes to IDLE, and `hi`/`lo` are unchanged.
  - `flush` with `start` in the same cycle: the start is dropped.
  - `flush` in IDLE: no effect; a simultaneous `wr_hi`/`wr_lo` is still applied.
- **Reset precedence:** `reset` overrides everything, including mid-operation.

## Timing
- **Issue latency:** a start accepted at edge E0 gives `busy`=1 from E0 through E0+LAT−1 (LAT cycles).
- **Commit:** at edge E0+LAT, `hi`/`lo` update and `busy` falls together. New values are visible in the first cycle `busy` is low.
- **Back-to-back:** a new `start` may be accepted on the commit edge's following cycle. Maximum issue rate is one op per LAT+1 cycles.
- **Flush latency:** `busy` falls the cycle after `flush` is sampled.
- **Outputs:** `hi`, `lo` and `busy` are registered; there is no combinational input-to-output path.

## Structure
- **Package `muldiv_pkg`:**
  - 4-bit op encoding constants (`MD_NONE` … `MD_MSUBU`); these must match the decoder's `MULOp` values 1–4.
  - State enum (IDLE, RUN).
  - Default latency constants.
- **Sub-module `muldiv_arith`:** purely combinational. Takes latched operands, op, and current {hi,lo}; produces the 2·WIDTH result with all sign, zero-divide and overflow rules.
- **Top level:** FSM, counter, operand/op latches and HI/LO registers.

## Test plan
All scenarios use WIDTH=32, MUL_LAT=5, DIV_LAT=10.

1. **Reset:** assert `reset` 2 cycles → `hi`=0, `lo`=0, `busy`=0. Then mult 3×4 → `busy` high exactly 5 cycles, then `lo`=12, `hi`=0.
2. **Signed vs unsigned multiply:**
   - mult 0xFFFFFFFF×2 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
   - multu with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
3. **Divide:**
   - div −7÷2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `busy` high 10 cycles.
   - divu 7÷0 → `lo`=0xFFFFFFFF, `hi`=7.
   - div 0x80000000÷0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
4. **Accumulate:**
   - mthi 0, mtlo 0xFFFFFFFF, then maddu 1×1 → `hi`=1, `lo`=0.
   - From `hi`=`lo`=0, msub 1×1 → `hi`=`lo`=0xFFFFFFFF.
   - mtlo 5 issued together with madd 2×3 → `lo`=11.
5. **Hazards:**
   - Div with a second `start` plus `wr_lo` in cycle 3 → both ignored; the div result commits unchanged at cycle 10.
   - A separate div flushed in cycle 4 → `busy`=0 the next cycle; `hi`/`lo` keep their pre-issue values.
6. **Reset mid-operation:** `reset` during cycle 2 of a mult after prior `hi`=`lo`=0x1234 → next cycle `busy`=0, `hi`=`lo`=0; no late commit.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// FSM state type, default latencies and small op-classification helpers.
package muldiv_pkg;

    // Op codes 1-4 line up with the decoder's MULOp field.
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MADD  = 4'd5;
    localparam logic [3:0] MD_MADDU = 4'd6;
    localparam logic [3:0] MD_MSUB  = 4'd7;
    localparam logic [3:0] MD_MSUBU = 4'd8;

    localparam int MD_WIDTH_DEF   = 32;
    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Codes 0 and 9..15 never start an operation.
    function automatic logic md_is_valid(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MSUBU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational HI/LO arithmetic: product, quotient/remainder and
// multiply-accumulate over the latched operands and the current {hi,lo}.
module muldiv_arith
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEF
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic               sgn;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quot_u;
    logic [WIDTH-1:0]   rem_u;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               div_zero;
    logic               div_ovf;

    // Result selection by op class; one shared magnitude divider serves div and divu.
    always_comb begin
        // NOTE: every output of this block is assigned before any branch, so no latch is inferred.
        result   = acc;
        sgn      = md_is_signed(op);
        ext_a    = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b    = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        // Low 2*WIDTH bits of the extended product are exact for both signednesses.
        product  = ext_a * ext_b;

        mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
        div_zero = (b == '0);
        quot_u   = div_zero ? '0 : mag_a / mag_b;
        rem_u    = div_zero ? '0 : mag_a % mag_b;
        // Truncate toward zero; remainder follows the dividend's sign.
        quot     = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -quot_u : quot_u;
        rem      = (sgn && a[WIDTH-1]) ? -rem_u : rem_u;
        div_ovf  = sgn && (a == MIN_VAL) && (b == '1);

        case (op)
            MD_MULT, MD_MULTU: result = product;
            MD_MADD, MD_MADDU: result = acc + product;
            MD_MSUB, MD_MSUBU: result = acc - product;
            MD_DIV, MD_DIVU: begin
                if (div_zero)
                    result = {a, {WIDTH{1'b1}}};
                else if (div_ovf)
                    result = {{WIDTH{1'b0}}, MIN_VAL};
                else
                    result = {rem, quot};
            end
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: issue FSM, latency counter,
// operand/op latches and the architectural HI and LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = MD_WIDTH_DEF,
    parameter int MUL_LAT = MD_MUL_LAT_DEF,  // >= 1
    parameter int DIV_LAT = MD_DIV_LAT_DEF   // >= 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mul_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               issue;
    logic [2*WIDTH-1:0] result;

    // The accumulator is {hi,lo} as it stands at commit time.
    muldiv_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .acc    ({hi, lo}),
        .result (result)
    );

    // Next-state, counter and HI/LO update decisions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi;
        lo_d    = lo;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start && !flush && md_is_valid(mul_op)) begin
                    issue   = 1'b1;
                    state_d = RUN;
                    count_d = md_is_div(mul_op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                end
            end
            RUN: begin
                // Flush beats a commit falling on the same edge.
                if (flush) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q <= CW'(1)) begin
                    state_d    = IDLE;
                    count_d    = '0;
                    {hi_d, lo_d} = result;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register here sample pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            hi      <= '0;
            lo      <= '0;
            // NOTE: the op/operand latches are reset too so no stale pending op survives reset.
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi      <= hi_d;
            lo      <= lo_d;
            if (issue) begin
                op_q <= mul_op;
                a_q  <= src_a;
                b_q  <= src_b;
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed test-plan vectors followed by
// randomized ops, all compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mul_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mul_op  (mul_op),
        .src_a   (src_a),
        .src_b   (src_b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference HI/LO result: MIPS semantics via native integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        logic [31:0] qv;
        logic [31:0] rv;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return acc + sp;
            OP_MADDU: return acc + up;
            OP_MSUB:  return acc - sp;
            OP_MSUBU: return acc - up;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q  = $signed(a) / $signed(b);
                r  = $signed(a) % $signed(b);
                qv = q;
                rv = r;
                return {rv, qv};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
        if (op >= OP_MULT && op <= OP_MSUBU) return MUL_LAT;
        return 0;
    endfunction

    // Issue one op (with optional same-cycle mthi/mtlo and flush), optionally
    // flush it after flush_at busy cycles, optionally inject a start+mthi/mtlo
    // in busy cycle 3, then compare the busy length and final HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic whi, input logic wlo,
                          input logic [31:0] wd, input logic flush_issue,
                          input int flush_at, input logic noise);
        int cycles;
        int exp_cycles;
        @(negedge clk);
        start = 1'b1; mul_op = op; src_a = a; src_b = b;
        wr_hi = whi; wr_lo = wlo; wr_data = wd; flush = flush_issue;
        @(negedge clk);
        start = 1'b0; mul_op = OP_NONE; wr_hi = 1'b0; wr_lo = 1'b0; flush = 1'b0;

        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        if (flush_issue || ref_lat(op) == 0) exp_cycles = 0;
        else if (flush_at != 0) exp_cycles = flush_at;
        else begin
            exp_cycles = ref_lat(op);
            {m_hi, m_lo} = ref_result(op, a, b, {m_hi, m_lo});
        end

        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            flush = (cycles == flush_at);
            if (noise && cycles == 3) begin
                start = 1'b1; mul_op = 4'($urandom_range(1, 8));
                src_a = $urandom; src_b = $urandom;
                wr_hi = 1'b1; wr_lo = 1'b1; wr_data = $urandom;
            end else begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; flush = 1'b0; mul_op = OP_NONE;

        check({tag, " busy_cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mul_op = OP_NONE; src_a = '0; src_b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; flush = 1'b0;
        m_hi = '0; m_lo = '0;

        // 1. Reset, then a first multiply.
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        run_op("mult 3x4", OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("mult 3x4 lo const", 64'(lo), 64'd12);

        // 2. Signed vs unsigned multiply.
        run_op("mult -1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("mult -1x2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // 3. Divide, divide-by-zero, signed overflow.
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("div -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu 7/0", OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("divu 7/0 const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);

        // 4. Accumulate, including a write coinciding with the issue.
        run_op("mthi 0", OP_NONE, '0, '0, 1'b1, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        run_op("mtlo -1", OP_NONE, '0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        run_op("maddu carry", OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("maddu carry const", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op("clear hilo", OP_NONE, '0, '0, 1'b1, 1'b1, 32'd0, 1'b0, 0, 1'b0);
        run_op("msub borrow", OP_MSUB, 32'd1, 32'd1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
        check("msub borrow const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("clear hilo 2", OP_NONE, '0, '0, 1'b1, 1'b1, 32'd0, 1'b0, 0, 1'b0);
        run_op("mtlo+madd", OP_MADD, 32'd2, 32'd3, 1'b0, 1'b1, 32'd5, 1'b0, 0, 1'b0);
        check("mtlo+madd const", 64'(lo), 64'd11);

        // 5. Hazards: ignored start/writes in RUN, flush mid-op, flush at issue.
        run_op("div noise", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, '0, 1'b0, 0, 1'b1);
        run_op("div flush", OP_DIV, 32'd55, 32'd3, 1'b0, 1'b0, '0, 1'b0, 4, 1'b0);
        run_op("flush at issue", OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 32'hABCD, 1'b1, 0, 1'b0);
        run_op("invalid op", 4'd12, 32'd9, 32'd9, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);

        // 6. Reset mid-operation.
        run_op("set 1234", OP_NONE, '0, '0, 1'b1, 1'b1, 32'h1234, 1'b0, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; mul_op = OP_MULT; src_a = 32'd7; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; mul_op = OP_NONE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hilo", {hi, lo}, 64'd0);
        repeat (8) @(negedge clk);
        check("midrst no late commit", {hi, lo}, 64'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            int         lat;
            int         fat;
            op  = 4'($urandom_range(0, 10));
            lat = ref_lat(op);
            fat = ($urandom_range(0, 5) == 0 && lat > 0) ? int'($urandom_range(1, lat)) : 0;
            run_op($sformatf("rand%0d op%0d", i, op), op, rand_operand(), rand_operand(),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
                   $urandom_range(0, 9) == 0, fat, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
